apb_slave_regbank: RTL
======================

# apb_slave_regbank

APB responder that terminates one `Pselx` line of the AHB-to-APB bridge and exposes a bank of 32-bit memory-mapped registers. It decodes setup/access phases, inserts a programmable number of wait states via `Pready`, returns read data on `PRdata`, and flags bad accesses on `Pslverr`. It is the peripheral-side counterpart used to close the loop in bridge simulations and as the template for real APB peripherals.

## Interface
- `SEL_IDX`, default 0: bit of `Pselx` this instance responds to (0..2).
- `NREGS`, default 16: register count, power of two, 2..64.
- `WAIT_CYCLES`, default 2: wait states inserted per transfer (0..15).
- `ID_VALUE`, default 32'hA5B0_0001: constant returned by read-only register `NREGS-1`.
- `Hclk`  in  1  sole clock, rising edge.
- `Hresetn`  in  1  reset, asynchronous, active-low.
- `Pselx`  in  3  bridge slave selects; only bit `SEL_IDX` used.
- `Penable`  in  1  APB access-phase strobe.
- `Pwrite`  in  1  1 = write, 0 = read.
- `Paddr`  in  32  byte address; only `Paddr[11:0]` (offset) decoded.
- `PWdata`  in  32  write data.
- `PRdata`  out  32  read data, valid while `Pready`=1 in access phase.
- `Pready`  out  1  transfer completes when high in access phase.
- `Pslverr`  out  1  error response, qualified by `Pready`.

## Operation
- `sel` = `Pselx[SEL_IDX]`. Word index = `Paddr[log2(NREGS)+1:2]`; `Paddr[1:0]` ignored.
- Error condition `err` = offset >= `NREGS*4`, or write to index `NREGS-1`.
- States: IDLE, ACCESS.
- IDLE: `sel`=1 and `Penable`=0 (setup phase) -> ACCESS; load wait counter `cnt` = `WAIT_CYCLES`; latch `err`, index, and read data (`ID_VALUE` for index `NREGS-1`, 0 on error) into `PRdata`. `sel` with `Penable`=1 in IDLE is a protocol violation: ignored, no write, stay IDLE.
- ACCESS: while `cnt`!=0, decrement once per cycle. Completion edge = `sel` & `Penable` & `cnt`==0: write commits (if `Pwrite` and not `err`), state -> IDLE.
- `sel` deasserted while in ACCESS: abort, no write, -> IDLE, `cnt` cleared.
- Registers 0..`NREGS-2` are R/W, reset to 0. Writes are full-word (no strobes).
- `Pready` = (`cnt`==0). `Pslverr` = latched `err` & `Pready` & state==ACCESS, else 0.
- `PRdata` forced to 0 in IDLE and for writes.

## Timing
- Reset values: state IDLE, `cnt` 0, all registers 0, `PRdata` 0, `Pready` 1, `Pslverr` 0.
- Setup at edge N -> `Pready` rises in cycle N+1+`WAIT_CYCLES`; `WAIT_CYCLES`=0 gives standard two-cycle APB transfer.
- Write data visible to a subsequent read's setup phase (next-cycle read-after-write is coherent).
- Back-to-back transfers: new setup accepted in the cycle after completion; no mandatory idle cycle.
- Reset asserted mid-ACCESS: immediate return to reset values; pending write dropped.

## Configuration
- `APB_SLV_WAIT_EN` defined: wait-state counter and `WAIT_CYCLES` active as above.
- Undefined: counter removed, `Pready` tied 1, every transfer completes in its first access cycle; `WAIT_CYCLES` ignored.

## Structure
- Package `apb_slv_pkg`: state enum (IDLE, ACCESS), offset width constant (12), default `ID_VALUE`, error-decode function.
- Sub-module `apb_slv_regbank`: register array with write port and combinational read mux; top level holds FSM, counter, response logic.

## Test plan
- Write 32'hDEAD_BEEF to offset 0x04, read 0x04 (`WAIT_CYCLES`=2) -> `Pready` low 2 access cycles, `PRdata`=32'hDEAD_BEEF, `Pslverr`=0.
- Read offset 0x3C (index 15) -> `PRdata`=32'hA5B0_0001; write 0 to 0x3C -> `Pslverr`=1, later read still 32'hA5B0_0001.
- Read offset 0x40 -> `Pslverr`=1, `PRdata`=0; write 0x40 -> `Pslverr`=1, no register changes.
- Drop `sel` during wait state of write to 0x08 -> no write, state IDLE, read 0x08 returns 0.
- Assert `Hresetn` low mid-access after writing 0x10 -> all outputs at reset values, read 0x10 returns 0.
- Build without `APB_SLV_WAIT_EN`: back-to-back write/read at 0x00 -> `Pready` constantly 1, each transfer two cycles.

Source files
------------

// File: rtl/apb_slv_pkg.sv
// -----------------------------------------------------------------------------
// apb_slv_pkg
// Shared definitions for the APB register-bank responder:
//   - FSM state encoding (IDLE / ACCESS)
//   - decoded offset width (12 bits of Paddr)
//   - default identification constant
//   - decode_err(): out-of-range offset or write to the read-only ID register
// -----------------------------------------------------------------------------
package apb_slv_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

    localparam int unsigned OFFS_W       = 12;
    localparam logic [31:0] ID_VALUE_DEF = 32'hA5B0_0001;

    // An access is bad when it falls past the bank or writes the top (ID) word.
    function automatic logic decode_err(input logic [OFFS_W-1:0] offs,
                                        input logic              wr,
                                        input int unsigned       nregs);
        logic [31:0] offs_ext;
        logic [31:0] word_idx;
        logic        oob;
        logic        ro_wr;
        offs_ext = {{(32 - OFFS_W){1'b0}}, offs};
        word_idx = {{(32 - OFFS_W + 2){1'b0}}, offs[OFFS_W-1:2]};
        oob      = (offs_ext >= (nregs * 32'd4));
        ro_wr    = wr && (word_idx == (nregs - 32'd1));
        return oob || ro_wr;
    endfunction

endpackage

// File: rtl/apb_slv_regbank.sv
// -----------------------------------------------------------------------------
// apb_slv_regbank
// Array of NREGS 32-bit registers with one full-word write port and a
// combinational read mux. The top entry is never written (the parent never
// issues a write to it) and reads of it are replaced by the ID constant
// upstream.
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset, clears every register
//   we_i     write enable
//   waddr_i  write word index
//   wdata_i  write data
//   raddr_i  read word index
//   rdata_o  read data (combinational)
// -----------------------------------------------------------------------------
module apb_slv_regbank #(
    parameter int unsigned NREGS = 16,
    parameter int unsigned IW    = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [IW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [IW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] regs_q [NREGS];

    // Register storage: cleared on reset, full-word write when enabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = regs_q[raddr_i];

endmodule

// File: rtl/apb_slave_regbank.sv
// -----------------------------------------------------------------------------
// apb_slave_regbank
// APB responder on one Pselx line exposing NREGS 32-bit registers; register
// NREGS-1 is a read-only ID word. Holds the IDLE/ACCESS FSM, the wait-state
// counter and the response logic; storage lives in apb_slv_regbank.
// Build option: APB_SLV_WAIT_EN - when defined, WAIT_CYCLES wait states are
// inserted per transfer via Pready; when undefined Pready is tied high.
// Ports:
//   Hclk     clock, rising edge
//   Hresetn  asynchronous active-low reset
//   Pselx    bridge selects, bit SEL_IDX used
//   Penable  access-phase strobe
//   Pwrite   1 = write, 0 = read
//   Paddr    byte address, low 12 bits decoded
//   PWdata   write data
//   PRdata   read data, zero in IDLE and for writes
//   Pready   transfer completes when high in ACCESS
//   Pslverr  error response, qualified by Pready
// -----------------------------------------------------------------------------
module apb_slave_regbank
    import apb_slv_pkg::*;
#(
    parameter int unsigned SEL_IDX     = 0,
    parameter int unsigned NREGS       = 16,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = ID_VALUE_DEF
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic [2:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] PWdata,
    output logic [31:0] PRdata,
    output logic        Pready,
    output logic        Pslverr
);

    localparam int unsigned IW = $clog2(NREGS);

    apb_state_e    state_q, state_d;
    logic          err_q, err_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0]   prdata_q, prdata_d;

    logic          sel_s;
    logic          setup_s;
    logic          complete_s;
    logic          abort_s;
    logic          cnt_zero_s;
    logic          err_s;
    logic          we_s;
    logic [IW-1:0] idx_s;
    logic [31:0]   rd_s;
    logic          unused_s;

    assign sel_s   = Pselx[SEL_IDX];
    assign idx_s   = Paddr[IW+1:2];
    assign err_s   = decode_err(Paddr[OFFS_W-1:0], Pwrite, NREGS);
    // Penable high while IDLE is a protocol violation and deliberately ignored.
    assign setup_s = (state_q == ST_IDLE) && sel_s && !Penable;
    assign abort_s = (state_q == ST_ACCESS) && !sel_s;
    assign complete_s = (state_q == ST_ACCESS) && sel_s && Penable && cnt_zero_s;
    assign we_s    = complete_s && Pwrite && !err_q;

    assign unused_s = ^{Paddr[31:OFFS_W], Paddr[1:0], Pselx};

`ifdef APB_SLV_WAIT_EN
    logic [3:0] cnt_q, cnt_d;

    assign cnt_zero_s = (cnt_q == 4'd0);

    // Wait counter: load on setup, count down in ACCESS, clear on abort.
    always_comb begin
        cnt_d = cnt_q;
        if (setup_s) begin
            cnt_d = 4'(WAIT_CYCLES);
        end else if (abort_s) begin
            cnt_d = 4'd0;
        end else if ((state_q == ST_ACCESS) && !cnt_zero_s) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Wait counter register.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_wait_s;

    assign unused_wait_s = (WAIT_CYCLES != 0);
    assign cnt_zero_s    = 1'b1;
`endif

    // Next state, latched error/index and read data for the current transfer.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        idx_d    = idx_q;
        prdata_d = prdata_q;
        case (state_q)
            ST_IDLE: begin
                if (setup_s) begin
                    state_d = ST_ACCESS;
                    err_d   = err_s;
                    idx_d   = idx_s;
                    if (err_s || Pwrite) begin
                        prdata_d = 32'd0;
                    end else if (idx_s == IW'(NREGS - 1)) begin
                        prdata_d = ID_VALUE;
                    end else begin
                        prdata_d = rd_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (abort_s || complete_s) begin
                    state_d  = ST_IDLE;
                    err_d    = 1'b0;
                    prdata_d = 32'd0;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                err_d    = 1'b0;
                prdata_d = 32'd0;
            end
        endcase
    end

    // FSM and transfer-context registers.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q  <= ST_IDLE;
            err_q    <= 1'b0;
            idx_q    <= {IW{1'b0}};
            prdata_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
            prdata_q <= prdata_d;
        end
    end

    apb_slv_regbank #(
        .NREGS (NREGS),
        .IW    (IW)
    ) u_regbank (
        .clk_i   (Hclk),
        .rst_ni  (Hresetn),
        .we_i    (we_s),
        .waddr_i (idx_q),
        .wdata_i (PWdata),
        .raddr_i (idx_s),
        .rdata_o (rd_s)
    );

    assign PRdata  = prdata_q;
    assign Pready  = cnt_zero_s;
    assign Pslverr = err_q & cnt_zero_s & (state_q == ST_ACCESS);

endmodule
